// File: rtl/spi_frame_if.sv
// spi_frame_if: SPI pins plus the assembled-word and frame-status bundle
interface spi_frame_if #(
  parameter int WORD_W    = 8,
  parameter int MAX_WORDS = 16
);
  localparam int IW = $clog2(MAX_WORDS + 1);
  logic          sck;
  logic          sdi;
  logic          cs;
  logic [WORD_W-1:0] word_data;
  logic          word_valid;
  logic [IW-1:0] word_idx;
  logic [IW-1:0] word_count;
  logic          frame_done;
  logic          frame_err;
  logic          busy;
  modport slave (
    input  sck, sdi, cs,
    output word_data, word_valid, word_idx, word_count, frame_done, frame_err, busy
  );
  modport master (
    output sck, sdi, cs,
    input  word_data, word_valid, word_idx, word_count, frame_done, frame_err, busy
  );
endinterface

// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver: mode-0 SPI slave that assembles MSB-first words and reports frame end/errors
module spi_frame_receiver #(
  parameter int WORD_W       = 8,
  parameter int MAX_WORDS    = 16,
  parameter int EXPECT_WORDS = 0,
  parameter int CS_ACTIVE    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input logic        clk,
  input logic        reset,
  spi_frame_if.slave bus
);
  localparam int IW = $clog2(MAX_WORDS + 1);
  localparam int BW = $clog2(WORD_W);
  typedef enum logic [1:0] {S_IDLE, S_RECEIVING, S_DONE} state_t;
  state_t state, next_state;
  logic [SYNC_STAGES-1:0] sck_s, sdi_s, cs_s;
  logic              sck_prev;
  logic [WORD_W-2:0] shift;
  logic [BW-1:0]     bit_cnt;
  logic [IW-1:0]     word_cnt;
  logic              ovf;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic [IW-1:0]     word_idx;
  logic              cs_act, sck_rise, sdi_sync;
  logic [WORD_W-1:0] nxt;
  assign sdi_sync = sdi_s[SYNC_STAGES-1];
  assign cs_act   = cs_s[SYNC_STAGES-1] == 1'(CS_ACTIVE);
  assign sck_rise = sck_s[SYNC_STAGES-1] & ~sck_prev;
  assign nxt      = {shift, sdi_sync};
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state == S_IDLE      ? (cs_act ? S_RECEIVING : S_IDLE) :
                 state == S_RECEIVING ? (cs_act ? S_RECEIVING : S_DONE) : S_IDLE;
  end
  // a rising sck in the cycle cs drops is deliberately ignored (cs_act gate)
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sck_s      <= '0;
      sdi_s      <= '0;
      cs_s       <= '0;
      sck_prev   <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      ovf        <= 1'b0;
      word_data  <= '0;
      word_valid <= 1'b0;
      word_idx   <= '0;
    end else begin
      sck_s      <= {sck_s[SYNC_STAGES-2:0], bus.sck};
      sdi_s      <= {sdi_s[SYNC_STAGES-2:0], bus.sdi};
      cs_s       <= {cs_s[SYNC_STAGES-2:0], bus.cs};
      sck_prev   <= sck_s[SYNC_STAGES-1];
      word_valid <= 1'b0;
      if (state == S_IDLE && cs_act) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
        ovf      <= 1'b0;
      end else if (state == S_RECEIVING && cs_act && sck_rise) begin
        shift <= nxt[WORD_W-2:0];
        if (bit_cnt == BW'(WORD_W - 1)) begin
          bit_cnt <= '0;
          if (word_cnt == IW'(MAX_WORDS)) ovf <= 1'b1;
          else begin
            word_data  <= nxt;
            word_valid <= 1'b1;
            word_idx   <= word_cnt;
            word_cnt   <= word_cnt + 1'b1;
          end
        end else bit_cnt <= bit_cnt + 1'b1;
      end
    end
  assign bus.word_data  = word_data;
  assign bus.word_valid = word_valid;
  assign bus.word_idx   = word_idx;
  assign bus.word_count = word_cnt;
  assign bus.frame_done = state == S_DONE;
  assign bus.busy       = state == S_RECEIVING;
  assign bus.frame_err  = state == S_DONE &&
                          (bit_cnt != '0 || ovf || (EXPECT_WORDS != 0 && word_cnt != IW'(EXPECT_WORDS)));
endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb_spi_frame_receiver: two receivers (active-high cs/expect 2, active-low cs/max 4) fed the same SPI traffic
module tb_spi_frame_receiver;
  localparam int SS = 2;
  logic clk = 0, reset = 0, sck = 0, sdi = 0, cs_on = 0;
  int n_chk = 0, n_fail = 0;
  int viol[2];
  bit fb[$];
  logic [15:0] cw[2][$], ew[2][$], cf[2][$], ef[2][$];
  spi_frame_if #(.WORD_W(8), .MAX_WORDS(16)) ia ();
  spi_frame_if #(.WORD_W(8), .MAX_WORDS(4))  ib ();
  assign ia.sck = sck;
  assign ia.sdi = sdi;
  assign ia.cs  = cs_on;
  assign ib.sck = sck;
  assign ib.sdi = sdi;
  assign ib.cs  = ~cs_on;
  spi_frame_receiver #(.WORD_W(8), .MAX_WORDS(16), .EXPECT_WORDS(2), .CS_ACTIVE(1), .SYNC_STAGES(SS))
    dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
  spi_frame_receiver #(.WORD_W(8), .MAX_WORDS(4), .EXPECT_WORDS(0), .CS_ACTIVE(0), .SYNC_STAGES(SS))
    dut_b (.clk(clk), .reset(reset), .bus(ib.slave));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ia.word_valid) cw[0].push_back({8'(ia.word_idx), ia.word_data});
    if (ib.word_valid) cw[1].push_back({8'(ib.word_idx), ib.word_data});
    if (ia.frame_done) cf[0].push_back({8'(ia.word_count), 7'd0, ia.frame_err});
    if (ib.frame_done) cf[1].push_back({8'(ib.word_count), 7'd0, ib.frame_err});
    if (ia.frame_err && !ia.frame_done) viol[0]++;
    if (ib.frame_err && !ib.frame_done) viol[1]++;
  end
  task automatic clear_q();
    for (int d = 0; d < 2; d++) begin
      cw[d].delete(); ew[d].delete(); cf[d].delete(); ef[d].delete(); viol[d] = 0;
    end
  endtask
  // reference: whole words MSB-first, saturating at MAX_WORDS, error rules from the frame's bit total
  task automatic add_frame();
    int nw, mx, ex, cnt;
    bit err;
    logic [7:0] w;
    nw = fb.size() / 8;
    for (int d = 0; d < 2; d++) begin
      mx  = d ? 4 : 16;
      ex  = d ? 0 : 2;
      cnt = nw < mx ? nw : mx;
      err = (fb.size() % 8 != 0) || nw > mx || (ex != 0 && cnt != ex);
      for (int i = 0; i < cnt; i++) begin
        w = '0;
        for (int j = 0; j < 8; j++) w = {w[6:0], fb[i*8+j]};
        ew[d].push_back({8'(i), w});
      end
      ef[d].push_back({8'(cnt), 7'd0, err});
    end
  endtask
  task automatic push_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) fb.push_back(v[i]);
  endtask
  task automatic send_bit(input bit b);
    sdi = b;
    #40 sck = 1;
    #40 sck = 0;
  endtask
  task automatic run_frame(input int gap);
    cs_on = 1;
    #40;
    foreach (fb[i]) send_bit(fb[i]);
    #40 cs_on = 0;
    add_frame();
    fb.delete();
    #(gap);
  endtask
  task automatic test_reset();
    clear_q();
    cs_on = 1;
    for (int i = 0; i < 6; i++) #20 sck = ~sck;
    #20;
    n_chk++; if ({ia.word_data, ia.word_valid, ia.word_idx, ia.word_count, ia.frame_done, ia.frame_err, ia.busy} !== '0) begin
      n_fail++; $display("FAIL reset outputs dut0: got %h want 0", {ia.word_data, ia.word_valid, ia.word_idx, ia.word_count, ia.frame_done, ia.frame_err, ia.busy});
    end
    n_chk++; if ({ib.word_data, ib.word_valid, ib.word_idx, ib.word_count, ib.frame_done, ib.frame_err, ib.busy} !== '0) begin
      n_fail++; $display("FAIL reset outputs dut1: got %h want 0", {ib.word_data, ib.word_valid, ib.word_idx, ib.word_count, ib.frame_done, ib.frame_err, ib.busy});
    end
    reset = 1;
    for (int i = 0; i < SS + 2; i++) begin
      @(posedge clk); #1;
      if (ia.busy && ib.busy) break;
    end
    n_chk++; if (ia.busy !== 1'b1) begin n_fail++; $display("FAIL reset busy-after-release dut0: got %b want 1", ia.busy); end
    n_chk++; if (ib.busy !== 1'b1) begin n_fail++; $display("FAIL reset busy-after-release dut1: got %b want 1", ib.busy); end
    #40 cs_on = 0;
    add_frame();
    #200;
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (cw[d].size() !== 0) begin n_fail++; $display("FAIL zero-length dut%0d words: got %0d want 0", d, cw[d].size()); end
      n_chk++; if (cf[d].size() !== 1) begin n_fail++; $display("FAIL zero-length dut%0d frames: got %0d want 1", d, cf[d].size()); end
      else begin n_chk++; if (cf[d][0] !== ef[d][0]) begin n_fail++; $display("FAIL zero-length dut%0d count/err: got %h want %h", d, cf[d][0], ef[d][0]); end end
    end
  endtask
  task automatic test_single();
    int lat;
    clear_q();
    cs_on = 1;
    #40;
    n_chk++; if ({ia.busy, ib.busy} !== 2'b11) begin n_fail++; $display("FAIL single busy: got %b want 11", {ia.busy, ib.busy}); end
    push_bits(8'hA5, 8);
    push_bits(8'h3C, 8);
    for (int i = 0; i < 15; i++) send_bit(fb[i]);
    sdi = fb[15];
    #40 sck = 1;
    lat = -1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      if (ia.word_valid) begin lat = j; break; end
    end
    n_chk++; if (lat !== SS) begin n_fail++; $display("FAIL single latency: got %0d want %0d", lat, SS); end
    n_chk++; if (ib.word_valid !== 1'b1) begin n_fail++; $display("FAIL single latency dut1 valid: got %b want 1", ib.word_valid); end
    #20 sck = 0;
    #40 cs_on = 0;
    add_frame();
    fb.delete();
    #200;
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (cw[d].size() !== ew[d].size()) begin n_fail++; $display("FAIL single dut%0d words: got %0d want %0d", d, cw[d].size(), ew[d].size()); end
      for (int i = 0; i < ew[d].size() && i < cw[d].size(); i++) begin
        n_chk++; if (cw[d][i] !== ew[d][i]) begin n_fail++; $display("FAIL single dut%0d word%0d idx/data: got %h want %h", d, i, cw[d][i], ew[d][i]); end
      end
      n_chk++; if (cf[d].size() !== ef[d].size()) begin n_fail++; $display("FAIL single dut%0d frames: got %0d want %0d", d, cf[d].size(), ef[d].size()); end
      for (int i = 0; i < ef[d].size() && i < cf[d].size(); i++) begin
        n_chk++; if (cf[d][i] !== ef[d][i]) begin n_fail++; $display("FAIL single dut%0d frame%0d count/err: got %h want %h", d, i, cf[d][i], ef[d][i]); end
      end
      n_chk++; if (viol[d] !== 0) begin n_fail++; $display("FAIL single dut%0d stray frame_err: got %0d want 0", d, viol[d]); end
    end
  endtask
  task automatic test_scenario(input string name, input int kind);
    clear_q();
    case (kind)
      0: begin push_bits(8'hFF, 8); push_bits(8'($urandom), 3); run_frame(200); end
      1: begin for (int i = 1; i <= 5; i++) push_bits(8'(i), 8); run_frame(200); end
      2: begin push_bits(8'($urandom), 8); run_frame(80); push_bits(8'h81, 8); run_frame(200); end
      3: begin
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        #80 push_bits(8'($urandom), 8); run_frame(200);
      end
      4: begin
        cs_on = 1;
        #40;
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        reset = 0;
        @(posedge clk); #1;
        n_chk++; if ({ia.word_data, ia.word_valid, ia.word_idx, ia.word_count, ia.frame_done, ia.busy} !== '0) begin
          n_fail++; $display("FAIL %s dut0 outputs in reset: got %h want 0", name, {ia.word_data, ia.word_valid, ia.word_idx, ia.word_count, ia.frame_done, ia.busy});
        end
        n_chk++; if ({ib.word_data, ib.word_valid, ib.word_idx, ib.word_count, ib.frame_done, ib.busy} !== '0) begin
          n_fail++; $display("FAIL %s dut1 outputs in reset: got %h want 0", name, {ib.word_data, ib.word_valid, ib.word_idx, ib.word_count, ib.frame_done, ib.busy});
        end
        #30 reset = 1;
        push_bits(8'h5A, 8);
        run_frame(200);
      end
      default: for (int f = 0; f < 6; f++) begin
        for (int i = $urandom_range(0, 47); i > 0; i--) fb.push_back(1'($urandom));
        run_frame(10 * $urandom_range(8, 20));
      end
    endcase
    #200;
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (cw[d].size() !== ew[d].size()) begin n_fail++; $display("FAIL %s dut%0d words: got %0d want %0d", name, d, cw[d].size(), ew[d].size()); end
      for (int i = 0; i < ew[d].size() && i < cw[d].size(); i++) begin
        n_chk++; if (cw[d][i] !== ew[d][i]) begin n_fail++; $display("FAIL %s dut%0d word%0d idx/data: got %h want %h", name, d, i, cw[d][i], ew[d][i]); end
      end
      n_chk++; if (cf[d].size() !== ef[d].size()) begin n_fail++; $display("FAIL %s dut%0d frames: got %0d want %0d", name, d, cf[d].size(), ef[d].size()); end
      for (int i = 0; i < ef[d].size() && i < cf[d].size(); i++) begin
        n_chk++; if (cf[d][i] !== ef[d][i]) begin n_fail++; $display("FAIL %s dut%0d frame%0d count/err: got %h want %h", name, d, i, cf[d][i], ef[d][i]); end
      end
      n_chk++; if (viol[d] !== 0) begin n_fail++; $display("FAIL %s dut%0d stray frame_err: got %0d want 0", name, d, viol[d]); end
    end
  endtask
  task automatic test_partial();      test_scenario("partial", 0);      endtask
  task automatic test_overflow();     test_scenario("overflow", 1);     endtask
  task automatic test_back_to_back(); test_scenario("back_to_back", 2); endtask
  task automatic test_idle_sck();     test_scenario("idle_sck", 3);     endtask
  task automatic test_reset_mid();    test_scenario("reset_mid", 4);    endtask
  task automatic test_random();       test_scenario("random", 5);       endtask
  initial begin
    #3;
    test_reset();
    test_single();
    test_partial();
    test_overflow();
    test_back_to_back();
    test_idle_sck();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
